dsky_serial_rx: RTL and testbench
=================================

Name: dsky_serial_rx

Overview:
- Serial command receiver that drives the CPU input registers DSKY_VERB_data, DSKY_NOUN_data, AXI_MISSION_TIME_data, AXI_APOGEE_data and AXI_PERIGEE_data in the top level. These are currently tied to zero.
- Receives 8N1 UART bytes from a ground/host link. Decodes 5-byte command frames and updates one 15-bit register per valid frame.
- It is the inbound counterpart of the IO_unit transmit path: IO_unit sends telemetry out, this block takes commands in.

Parameters:
- CLKS_PER_BIT, 434, core clock cycles per UART bit. Minimum 8.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_BITS, 40, inter-byte timeout in bit times while a frame is in progress.

Ports:
- clock, input, 1, core clock.
- reset_n, input, 1, asynchronous active-low reset.
- rx, input, 1, asynchronous serial line. Idle high.
- DSKY_VERB_data, output, 15, register for select 0.
- DSKY_NOUN_data, output, 15, register for select 1.
- AXI_MISSION_TIME_data, output, 15, register for select 2.
- AXI_APOGEE_data, output, 15, register for select 3.
- AXI_PERIGEE_data, output, 15, register for select 4.
- update_valid, output, 1, one-cycle pulse when a register is written.
- update_sel, output, 3, select of the last write. Held until the next write.
- frame_err, output, 1, one-cycle pulse on any rejected frame or byte.
- err_count, output, 8, saturating count of frame_err pulses.

Behaviour:
- Reset (asynchronous):
  - All five data registers, update_sel and err_count go to 0.
  - update_valid and frame_err go to 0.
  - Both rx synchronizer flops go to 1.
  - Bit FSM goes to IDLE and parser goes to WAIT_SYNC.
  - Reset asserted mid-byte or mid-frame discards all partial data; no write occurs.
- rx synchronization: two-flop synchronizer. All logic uses the synchronized value rx_s.
- Bit FSM:
  - IDLE: on a 1->0 transition of rx_s, go to START and clear the counter.
  - START: after CLKS_PER_BIT/2 cycles, sample rx_s. If 0, go to DATA. If 1, treat as a glitch and return to IDLE with no error.
  - DATA: sample every CLKS_PER_BIT cycles, 8 samples, LSB first.
  - STOP: sample CLKS_PER_BIT cycles after the last data bit.
    - If 1: pulse byte_valid (internal) with the byte.
    - If 0: framing error. Pulse frame_err, force the parser to WAIT_SYNC, then wait in IDLE until rx_s=1 before re-arming.
- Parser FSM (advances only on byte_valid):
  - WAIT_SYNC: byte == SYNC_BYTE goes to GET_SEL. Any other byte is ignored with no error.
  - GET_SEL: store sel. If sel > 4, pulse frame_err and go to WAIT_SYNC. Otherwise go to GET_HI.
  - GET_HI: store hi. If hi[7]=1, pulse frame_err and go to WAIT_SYNC. Otherwise go to GET_LO.
  - GET_LO: store lo, go to GET_SUM.
  - GET_SUM: required checksum is sel ^ hi ^ lo (8-bit).
    - Match: register[sel] <= {hi[6:0], lo}. update_valid pulses and update_sel <= sel.
    - Mismatch: pulse frame_err, no write.
    - Either case: go to WAIT_SYNC.
- Latency: the register write and the update_valid pulse occur on the clock edge one cycle after the byte_valid of the checksum byte. The new register value is visible in the same cycle update_valid is high.
- Timeout: in any parser state other than WAIT_SYNC, if no byte_valid occurs for TIMEOUT_BITS*CLKS_PER_BIT cycles, pulse frame_err and go to WAIT_SYNC. The timeout counter clears on each byte_valid.
- A SYNC_BYTE value received in a non-sync state is treated as data, not as a resync.
- Simultaneous events: a framing error and a timeout expiring on the same cycle produce a single frame_err pulse.
- err_count increments by 1 per frame_err pulse and saturates at 255 with no wrap.
- Registers not addressed by a frame hold their values. There is no read-clear.

Test Plan (CLKS_PER_BIT=16, TIMEOUT_BITS=40):
- Send A5 00 12 34 26 -> DSKY_VERB_data=15'h1234, update_valid for one cycle, update_sel=0, all other registers 0, err_count=0.
- Send A5 04 7F FF 84 -> AXI_PERIGEE_data=15'h7FFF, update_sel=4. Then send A5 04 00 01 05 -> AXI_PERIGEE_data=15'h0001.
- Send 00 FF A5 01 00 21 20 -> leading bytes ignored with no error, DSKY_NOUN_data=15'h0021, err_count=0.
- Send bad checksum A5 02 01 02 00 -> frame_err pulse, err_count=1, AXI_MISSION_TIME_data unchanged. Then A5 05 ... -> err_count=2. Then A5 03 80 00 83 -> err_count=3, no writes.
- Send A5 03 then idle for 41 bit times -> exactly one frame_err pulse. A following full frame A5 03 00 07 04 -> AXI_APOGEE_data=15'h0007.
- Stop bit driven 0 mid-frame -> frame_err, parser resyncs. Also: a 4-cycle low glitch on idle rx -> no byte and no error. Also: reset_n pulsed low mid-byte -> all outputs return to 0, and the next valid frame decodes correctly.

Source files
------------

// File: rtl/dsky_serial_rx.sv
// -----------------------------------------------------------------------------
// dsky_serial_rx
//
// Inbound command receiver for the ground/host link. Takes 8N1 UART bytes on
// rx, assembles 5-byte command frames and writes one 15-bit CPU input register
// per valid frame. It is the receive-side counterpart of the IO_unit telemetry
// transmitter.
//
// Frame layout: SYNC_BYTE, sel, hi, lo, sum   where sum = sel ^ hi ^ lo
//   sel 0..4 selects the register, hi[7] must be 0, data = {hi[6:0], lo}.
//
// Ports
//   clock                  core clock
//   reset_n                asynchronous active-low reset
//   rx                     asynchronous serial line, idle high
//   DSKY_VERB_data         register for select 0
//   DSKY_NOUN_data         register for select 1
//   AXI_MISSION_TIME_data  register for select 2
//   AXI_APOGEE_data        register for select 3
//   AXI_PERIGEE_data       register for select 4
//   update_valid           one-cycle pulse when a register is written
//   update_sel             select of the last write, held until the next one
//   frame_err              one-cycle pulse on any rejected frame or byte
//   err_count              saturating count of frame_err pulses
// -----------------------------------------------------------------------------
module dsky_serial_rx #(
   parameter int unsigned CLKS_PER_BIT = 434,   // minimum 8
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
   parameter int unsigned TIMEOUT_BITS = 40
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        rx,
   output logic [14:0] DSKY_VERB_data,
   output logic [14:0] DSKY_NOUN_data,
   output logic [14:0] AXI_MISSION_TIME_data,
   output logic [14:0] AXI_APOGEE_data,
   output logic [14:0] AXI_PERIGEE_data,
   output logic        update_valid,
   output logic [2:0]  update_sel,
   output logic        frame_err,
   output logic [7:0]  err_count
);

   localparam int unsigned NUM_REGS   = 5;
   localparam int unsigned CNT_W      = $clog2(CLKS_PER_BIT);
   localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TMO_W      = $clog2(TMO_CYCLES);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYCLES - 1);

   typedef enum logic [1:0] {
      B_IDLE,
      B_START,
      B_DATA,
      B_STOP
   } bit_state_t;

   typedef enum logic [2:0] {
      P_WAIT_SYNC,
      P_GET_SEL,
      P_GET_HI,
      P_GET_LO,
      P_GET_SUM
   } parse_state_t;

   // ---------------------------------------------------------------------------
   // rx synchronizer. rx_prev is one more stage, used only for edge detection.
   // ---------------------------------------------------------------------------
   logic rx_meta;
   logic rx_s;
   logic rx_prev;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples the
   // pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // ---------------------------------------------------------------------------
   // Bit FSM
   // ---------------------------------------------------------------------------
   bit_state_t       bit_state;
   bit_state_t       bit_next;
   logic [CNT_W-1:0] bit_cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shift_reg;
   logic             cnt_clr;
   logic             sample_data;
   logic             stop_ok;
   logic             stop_bad;
   logic             byte_valid;
   logic             byte_err;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) bit_state <= B_IDLE;
      else          bit_state <= bit_next;
   end

   // NOTE: every always_comb output gets a default first so no path leaves a
   // variable unassigned, which would infer a latch.
   always_comb begin
      bit_next = bit_state;
      unique case (bit_state)
         // Only a genuine 1->0 transition arms a byte. After a framing error
         // the line is still low, so the next byte cannot start until rx_s
         // has returned high and fallen again.
         B_IDLE:  if (rx_prev && !rx_s) bit_next = B_START;
         // A start bit that is high again at mid-bit is a glitch: drop it.
         B_START: if (bit_cnt == HALF_LAST) bit_next = rx_s ? B_IDLE : B_DATA;
         B_DATA:  if (bit_cnt == BIT_LAST && bit_idx == 3'd7) bit_next = B_STOP;
         B_STOP:  if (bit_cnt == BIT_LAST) bit_next = B_IDLE;
         default: bit_next = B_IDLE;
      endcase
   end

   always_comb begin
      sample_data = (bit_state == B_DATA) && (bit_cnt == BIT_LAST);
      stop_ok     = (bit_state == B_STOP) && (bit_cnt == BIT_LAST) &&  rx_s;
      stop_bad    = (bit_state == B_STOP) && (bit_cnt == BIT_LAST) && !rx_s;
      cnt_clr     = (bit_state == B_IDLE) || (bit_next != bit_state) || sample_data;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         bit_cnt    <= '0;
         bit_idx    <= '0;
         shift_reg  <= '0;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
      end else begin
         bit_cnt <= cnt_clr ? '0 : bit_cnt + 1'b1;
         if (bit_state == B_START) bit_idx <= '0;
         else if (sample_data)     bit_idx <= bit_idx + 1'b1;
         // LSB arrives first, so shift in from the top.
         if (sample_data) shift_reg <= {rx_s, shift_reg[7:1]};
         byte_valid <= stop_ok;
         byte_err   <= stop_bad;
      end
   end

   // shift_reg is stable from the stop bit until the next byte's first data
   // sample, so it serves directly as the received byte.
   logic [7:0] rx_byte;
   assign rx_byte = shift_reg;

   // ---------------------------------------------------------------------------
   // Parser FSM
   // ---------------------------------------------------------------------------
   parse_state_t     parse_state;
   parse_state_t     parse_next;
   logic [2:0]       sel_q;
   logic [7:0]       hi_q;
   logic [7:0]       lo_q;
   logic [7:0]       sum_exp;
   logic [TMO_W-1:0] tmo_cnt;
   logic             timeout_hit;
   logic             sel_bad;
   logic             hi_bad;
   logic             sum_bad;
   logic             err_set;
   logic             wr_en;

   assign sum_exp     = {5'd0, sel_q} ^ hi_q ^ lo_q;
   assign sel_bad     = rx_byte > 8'd4;
   assign hi_bad      = rx_byte[7];
   assign sum_bad     = rx_byte != sum_exp;
   assign timeout_hit = (parse_state != P_WAIT_SYNC) && !byte_valid && (tmo_cnt == TMO_LAST);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) parse_state <= P_WAIT_SYNC;
      else          parse_state <= parse_next;
   end

   always_comb begin
      parse_next = parse_state;
      if (byte_valid) begin
         unique case (parse_state)
            // A sync value seen in any later state is ordinary data.
            P_WAIT_SYNC: if (rx_byte == SYNC_BYTE) parse_next = P_GET_SEL;
            P_GET_SEL:   parse_next = sel_bad ? P_WAIT_SYNC : P_GET_HI;
            P_GET_HI:    parse_next = hi_bad  ? P_WAIT_SYNC : P_GET_LO;
            P_GET_LO:    parse_next = P_GET_SUM;
            P_GET_SUM:   parse_next = P_WAIT_SYNC;
            default:     parse_next = P_WAIT_SYNC;
         endcase
      end
      if (byte_err || timeout_hit) parse_next = P_WAIT_SYNC;
   end

   always_comb begin
      wr_en   = 1'b0;
      err_set = byte_err || timeout_hit;
      if (byte_valid) begin
         unique case (parse_state)
            P_GET_SEL: err_set = err_set || sel_bad;
            P_GET_HI:  err_set = err_set || hi_bad;
            P_GET_SUM: begin
               wr_en   = !sum_bad;
               err_set = err_set || sum_bad;
            end
            default: ;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // Frame fields, timeout counter, register file and status outputs
   // ---------------------------------------------------------------------------
   logic [14:0] regs [NUM_REGS];

   // NOTE: the register file is only five words and must read zero after
   // reset, so it is reset like any other flop rather than left as memory.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sel_q        <= '0;
         hi_q         <= '0;
         lo_q         <= '0;
         tmo_cnt      <= '0;
         update_valid <= 1'b0;
         update_sel   <= '0;
         frame_err    <= 1'b0;
         err_count    <= '0;
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else begin
         if (byte_valid && parse_state == P_GET_SEL) sel_q <= rx_byte[2:0];
         if (byte_valid && parse_state == P_GET_HI)  hi_q  <= rx_byte;
         if (byte_valid && parse_state == P_GET_LO)  lo_q  <= rx_byte;

         if (parse_state == P_WAIT_SYNC || byte_valid || timeout_hit) tmo_cnt <= '0;
         else                                                         tmo_cnt <= tmo_cnt + 1'b1;

         for (int i = 0; i < NUM_REGS; i++) begin
            if (wr_en && sel_q == 3'(i)) regs[i] <= {hi_q[6:0], lo_q};
         end

         update_valid <= wr_en;
         if (wr_en) update_sel <= sel_q;

         // Framing error, timeout and parse errors merge into err_set, so
         // coincident causes still give a single pulse and a single count.
         frame_err <= err_set;
         if (err_set && err_count != 8'hFF) err_count <= err_count + 1'b1;
      end
   end

   assign DSKY_VERB_data        = regs[0];
   assign DSKY_NOUN_data        = regs[1];
   assign AXI_MISSION_TIME_data = regs[2];
   assign AXI_APOGEE_data       = regs[3];
   assign AXI_PERIGEE_data      = regs[4];

endmodule

// File: tb/tb_dsky_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_dsky_serial_rx
//
// Directed bench for dsky_serial_rx at CLKS_PER_BIT=16, TIMEOUT_BITS=40.
// Serial stimulus is driven on the falling clock edge; outputs are observed on
// the falling edge too. Pulse monitors keep running totals of update_valid and
// frame_err cycles so each scenario can compare the change it caused.
// -----------------------------------------------------------------------------
module tb_dsky_serial_rx;

   localparam int CPB = 16;

   logic        clock = 1'b0;
   logic        reset_n = 1'b0;
   logic        rx = 1'b1;
   logic [14:0] DSKY_VERB_data;
   logic [14:0] DSKY_NOUN_data;
   logic [14:0] AXI_MISSION_TIME_data;
   logic [14:0] AXI_APOGEE_data;
   logic [14:0] AXI_PERIGEE_data;
   logic        update_valid;
   logic [2:0]  update_sel;
   logic        frame_err;
   logic [7:0]  err_count;

   int compared   = 0;
   int mismatched = 0;

   int          uv_total = 0;
   int          fe_total = 0;
   logic [14:0] uv_val   = '0;
   int          uv_base;
   int          fe_base;

   dsky_serial_rx #(
      .CLKS_PER_BIT(CPB),
      .SYNC_BYTE   (8'hA5),
      .TIMEOUT_BITS(40)
   ) dut (
      .clock                (clock),
      .reset_n              (reset_n),
      .rx                   (rx),
      .DSKY_VERB_data       (DSKY_VERB_data),
      .DSKY_NOUN_data       (DSKY_NOUN_data),
      .AXI_MISSION_TIME_data(AXI_MISSION_TIME_data),
      .AXI_APOGEE_data      (AXI_APOGEE_data),
      .AXI_PERIGEE_data     (AXI_PERIGEE_data),
      .update_valid         (update_valid),
      .update_sel           (update_sel),
      .frame_err            (frame_err),
      .err_count            (err_count)
   );

   always #5 clock = ~clock;

   // Pulse monitors; uv_val records the selected register in the same cycle
   // update_valid is high.
   always @(negedge clock) begin
      if (update_valid) begin
         uv_total <= uv_total + 1;
         case (update_sel)
            3'd0:    uv_val <= DSKY_VERB_data;
            3'd1:    uv_val <= DSKY_NOUN_data;
            3'd2:    uv_val <= AXI_MISSION_TIME_data;
            3'd3:    uv_val <= AXI_APOGEE_data;
            default: uv_val <= AXI_PERIGEE_data;
         endcase
      end
      if (frame_err) fe_total <= fe_total + 1;
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic idle(input int n);
      rx = 1'b1;
      repeat (n) @(negedge clock);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop_bit);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clock);
      end
      rx = stop_bit;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
      if (!stop_bit) repeat (CPB) @(negedge clock);
   endtask

   task automatic send_frame(input logic [7:0] s, c, h, l, k);
      send_byte(s, 1'b1);
      send_byte(c, 1'b1);
      send_byte(h, 1'b1);
      send_byte(l, 1'b1);
      send_byte(k, 1'b1);
      idle(4);
   endtask

   task automatic mark();
      uv_base = uv_total;
      fe_base = fe_total;
   endtask

   // ---------------------------------------------------------------------------
   // Scenarios
   // ---------------------------------------------------------------------------
   task automatic test_reset();
      reset_n = 1'b0;
      rx = 1'b1;
      repeat (4) @(negedge clock);
      compared++;
      if ({DSKY_VERB_data, DSKY_NOUN_data, AXI_MISSION_TIME_data, AXI_APOGEE_data,
           AXI_PERIGEE_data} !== 75'd0) begin
         mismatched++;
         $display("FAIL reset_regs: got %h %h %h %h %h expected all 0", DSKY_VERB_data,
                  DSKY_NOUN_data, AXI_MISSION_TIME_data, AXI_APOGEE_data, AXI_PERIGEE_data);
      end
      reset_n = 1'b1;
      idle(4);
      compared++;
      if (update_valid !== 1'b0 || frame_err !== 1'b0) begin
         mismatched++;
         $display("FAIL reset_pulses: got uv=%b fe=%b expected 0 0", update_valid, frame_err);
      end
      compared++;
      if (update_sel !== 3'd0) begin
         mismatched++;
         $display("FAIL reset_sel: got %0d expected 0", update_sel);
      end
      compared++;
      if (err_count !== 8'd0) begin
         mismatched++;
         $display("FAIL reset_err_count: got %0d expected 0", err_count);
      end
   endtask

   task automatic test_verb();
      mark();
      send_frame(8'hA5, 8'h00, 8'h12, 8'h34, 8'h26);
      compared++;
      if (DSKY_VERB_data !== 15'h1234) begin
         mismatched++;
         $display("FAIL verb_data: got %h expected 1234", DSKY_VERB_data);
      end
      compared++;
      if (uv_total - uv_base !== 1) begin
         mismatched++;
         $display("FAIL verb_uv_cycles: got %0d expected 1", uv_total - uv_base);
      end
      compared++;
      if (uv_val !== 15'h1234) begin
         mismatched++;
         $display("FAIL verb_visible_with_uv: got %h expected 1234", uv_val);
      end
      compared++;
      if (update_sel !== 3'd0) begin
         mismatched++;
         $display("FAIL verb_sel: got %0d expected 0", update_sel);
      end
      compared++;
      if ({DSKY_NOUN_data, AXI_MISSION_TIME_data, AXI_APOGEE_data, AXI_PERIGEE_data} !== 60'd0) begin
         mismatched++;
         $display("FAIL verb_others: got %h %h %h %h expected all 0", DSKY_NOUN_data,
                  AXI_MISSION_TIME_data, AXI_APOGEE_data, AXI_PERIGEE_data);
      end
      compared++;
      if (err_count !== 8'd0 || fe_total - fe_base !== 0) begin
         mismatched++;
         $display("FAIL verb_no_err: got count=%0d pulses=%0d expected 0 0", err_count,
                  fe_total - fe_base);
      end
   endtask

   task automatic test_perigee();
      send_frame(8'hA5, 8'h04, 8'h7F, 8'hFF, 8'h84);
      compared++;
      if (AXI_PERIGEE_data !== 15'h7FFF) begin
         mismatched++;
         $display("FAIL perigee_max: got %h expected 7fff", AXI_PERIGEE_data);
      end
      compared++;
      if (update_sel !== 3'd4) begin
         mismatched++;
         $display("FAIL perigee_sel: got %0d expected 4", update_sel);
      end
      send_frame(8'hA5, 8'h04, 8'h00, 8'h01, 8'h05);
      compared++;
      if (AXI_PERIGEE_data !== 15'h0001) begin
         mismatched++;
         $display("FAIL perigee_overwrite: got %h expected 0001", AXI_PERIGEE_data);
      end
      compared++;
      if (DSKY_VERB_data !== 15'h1234) begin
         mismatched++;
         $display("FAIL verb_hold: got %h expected 1234", DSKY_VERB_data);
      end
   endtask

   task automatic test_leading_bytes();
      mark();
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_frame(8'hA5, 8'h01, 8'h00, 8'h21, 8'h20);
      compared++;
      if (DSKY_NOUN_data !== 15'h0021) begin
         mismatched++;
         $display("FAIL noun_data: got %h expected 0021", DSKY_NOUN_data);
      end
      compared++;
      if (update_sel !== 3'd1) begin
         mismatched++;
         $display("FAIL noun_sel: got %0d expected 1", update_sel);
      end
      compared++;
      if (err_count !== 8'd0 || fe_total - fe_base !== 0) begin
         mismatched++;
         $display("FAIL leading_no_err: got count=%0d pulses=%0d expected 0 0", err_count,
                  fe_total - fe_base);
      end
   endtask

   task automatic test_errors();
      mark();
      send_frame(8'hA5, 8'h02, 8'h01, 8'h02, 8'h00);
      compared++;
      if (fe_total - fe_base !== 1 || err_count !== 8'd1) begin
         mismatched++;
         $display("FAIL bad_sum: got pulses=%0d count=%0d expected 1 1", fe_total - fe_base,
                  err_count);
      end
      compared++;
      if (AXI_MISSION_TIME_data !== 15'h0000) begin
         mismatched++;
         $display("FAIL bad_sum_no_write: got %h expected 0000", AXI_MISSION_TIME_data);
      end
      send_frame(8'hA5, 8'h05, 8'h00, 8'h00, 8'h05);
      compared++;
      if (err_count !== 8'd2) begin
         mismatched++;
         $display("FAIL bad_sel: got count=%0d expected 2", err_count);
      end
      send_frame(8'hA5, 8'h03, 8'h80, 8'h00, 8'h83);
      compared++;
      if (err_count !== 8'd3 || AXI_APOGEE_data !== 15'h0000) begin
         mismatched++;
         $display("FAIL bad_hi: got count=%0d apogee=%h expected 3 0000", err_count,
                  AXI_APOGEE_data);
      end
      compared++;
      if (uv_total - uv_base !== 0) begin
         mismatched++;
         $display("FAIL bad_frames_no_write: got %0d writes expected 0", uv_total - uv_base);
      end
   endtask

   task automatic test_timeout();
      mark();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h03, 1'b1);
      idle(41 * CPB);
      compared++;
      if (fe_total - fe_base !== 1 || err_count !== 8'd4) begin
         mismatched++;
         $display("FAIL timeout: got pulses=%0d count=%0d expected 1 4", fe_total - fe_base,
                  err_count);
      end
      send_frame(8'hA5, 8'h03, 8'h00, 8'h07, 8'h04);
      compared++;
      if (AXI_APOGEE_data !== 15'h0007) begin
         mismatched++;
         $display("FAIL after_timeout: got %h expected 0007", AXI_APOGEE_data);
      end
   endtask

   task automatic test_stop_err();
      mark();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h02, 1'b1);
      send_byte(8'h00, 1'b0);
      // Tail that would complete a write of 0009 if the parser did not resync.
      send_byte(8'h00, 1'b1);
      send_byte(8'h09, 1'b1);
      send_byte(8'h0B, 1'b1);
      idle(4);
      compared++;
      if (fe_total - fe_base !== 1 || err_count !== 8'd5) begin
         mismatched++;
         $display("FAIL stop_err: got pulses=%0d count=%0d expected 1 5", fe_total - fe_base,
                  err_count);
      end
      compared++;
      if (uv_total - uv_base !== 0 || AXI_MISSION_TIME_data !== 15'h0000) begin
         mismatched++;
         $display("FAIL stop_err_resync: got writes=%0d mt=%h expected 0 0000",
                  uv_total - uv_base, AXI_MISSION_TIME_data);
      end
      send_frame(8'hA5, 8'h02, 8'h00, 8'h55, 8'h57);
      compared++;
      if (AXI_MISSION_TIME_data !== 15'h0055) begin
         mismatched++;
         $display("FAIL after_stop_err: got %h expected 0055", AXI_MISSION_TIME_data);
      end
   endtask

   task automatic test_glitch();
      idle(8);
      mark();
      rx = 1'b0;
      repeat (4) @(negedge clock);
      idle(3 * CPB);
      compared++;
      if (fe_total - fe_base !== 0 || uv_total - uv_base !== 0 || err_count !== 8'd5) begin
         mismatched++;
         $display("FAIL glitch: got err=%0d writes=%0d count=%0d expected 0 0 5",
                  fe_total - fe_base, uv_total - uv_base, err_count);
      end
   endtask

   task automatic test_reset_mid();
      send_byte(8'hA5, 1'b1);
      send_byte(8'h04, 1'b1);
      rx = 1'b0;
      repeat (CPB) @(negedge clock);
      rx = 1'b1;
      repeat (2 * CPB) @(negedge clock);
      rx = 1'b0;
      repeat (CPB / 2) @(negedge clock);
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      rx = 1'b1;
      reset_n = 1'b1;
      mark();
      idle(20 * CPB);
      compared++;
      if ({DSKY_VERB_data, DSKY_NOUN_data, AXI_MISSION_TIME_data, AXI_APOGEE_data,
           AXI_PERIGEE_data} !== 75'd0) begin
         mismatched++;
         $display("FAIL reset_mid_regs: got %h %h %h %h %h expected all 0", DSKY_VERB_data,
                  DSKY_NOUN_data, AXI_MISSION_TIME_data, AXI_APOGEE_data, AXI_PERIGEE_data);
      end
      compared++;
      if (err_count !== 8'd0 || update_sel !== 3'd0 || fe_total - fe_base !== 0 ||
          uv_total - uv_base !== 0) begin
         mismatched++;
         $display("FAIL reset_mid_status: got count=%0d sel=%0d err=%0d writes=%0d expected 0 0 0 0",
                  err_count, update_sel, fe_total - fe_base, uv_total - uv_base);
      end
      send_frame(8'hA5, 8'h00, 8'h00, 8'h2A, 8'h2A);
      compared++;
      if (DSKY_VERB_data !== 15'h002A || AXI_PERIGEE_data !== 15'h0000) begin
         mismatched++;
         $display("FAIL reset_mid_next: got verb=%h perigee=%h expected 002a 0000",
                  DSKY_VERB_data, AXI_PERIGEE_data);
      end
   endtask

   task automatic test_err_saturate();
      mark();
      for (int i = 0; i < 256; i++) send_byte(8'h00, 1'b0);
      idle(4);
      compared++;
      if (fe_total - fe_base !== 256) begin
         mismatched++;
         $display("FAIL sat_pulses: got %0d expected 256", fe_total - fe_base);
      end
      compared++;
      if (err_count !== 8'd255) begin
         mismatched++;
         $display("FAIL sat_count: got %0d expected 255", err_count);
      end
      compared++;
      if (DSKY_VERB_data !== 15'h002A) begin
         mismatched++;
         $display("FAIL sat_verb_hold: got %h expected 002a", DSKY_VERB_data);
      end
   endtask

   initial begin
      test_reset();
      test_verb();
      test_perigee();
      test_leading_bytes();
      test_errors();
      test_timeout();
      test_stop_err();
      test_glitch();
      test_reset_mid();
      test_err_saturate();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
